// File: rtl/serial_bus_pkg.sv
// Shared definitions for the serial bus: arbiter state encoding and the
// start-sequence length used by masters, slaves and the arbiter alike.
package serial_bus_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    BUSY    = 2'd2,
    RELEASE = 2'd3
  } bus_state_e;

  localparam int START_LEN = 3;
  localparam int ONES_W    = $clog2(START_LEN + 1);

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin picker: first requester after last_owner,
// wrapping modulo N, returned as both one-hot and index.
module rr_select #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_owner,
  output logic [N-1:0]  winner,
  output logic [IW-1:0] winner_idx,
  output logic          valid
);

  int idx;

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    winner     = '0;
    winner_idx = '0;
    valid      = 1'b0;
    idx        = 0;
    for (int i = 1; i <= N; i++) begin
      idx = (int'(last_owner) + i) % N;
      if (!valid && req[idx]) begin
        winner[idx] = 1'b1;
        winner_idx  = IW'(idx);
        valid       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/serial_bus_arbiter.sv
// Round-robin arbiter and master/slave multiplexer for the shared serial bus,
// with start-sequence timeout and a one-cycle idle gap between owners.
module serial_bus_arbiter
  import serial_bus_pkg::*;
#(
  parameter int MASTERS = 2,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [MASTERS-1:0] req,
  output logic [MASTERS-1:0] grant,
  input  logic [MASTERS-1:0] m_control,
  input  logic [MASTERS-1:0] m_wD,
  input  logic [MASTERS-1:0] m_valid,
  input  logic [MASTERS-1:0] m_last,
  output logic               control,
  output logic               wD,
  output logic               valid,
  output logic               last,
  input  logic               ready,
  input  logic               rD,
  output logic [MASTERS-1:0] m_ready,
  output logic [MASTERS-1:0] m_rD,
  output logic               busy,
  output logic               timeout_err
);

  localparam int IW = $clog2(MASTERS);
  localparam int CW = $clog2(TIMEOUT + 1);

  bus_state_e        state, state_nxt;
  logic [IW-1:0]     last_owner, owner_idx, sel_idx;
  logic [MASTERS-1:0] sel_onehot;
  logic              sel_valid;
  logic [CW-1:0]     cnt;
  logic [ONES_W-1:0] ones;
  logic              owner_req, start_hit, timeout_hit, revoke;

  rr_select #(.N(MASTERS), .IW(IW)) u_rr_select (
    .req        (req),
    .last_owner (last_owner),
    .winner     (sel_onehot),
    .winner_idx (sel_idx),
    .valid      (sel_valid)
  );

  // A start completing on the same edge as the deadline still wins the bus.
  assign owner_req   = |(req & grant);
  assign start_hit   = control && (ones == ONES_W'(START_LEN - 1));
  assign timeout_hit = (cnt >= CW'(TIMEOUT - 1));
  assign revoke      = (state == GRANT) && owner_req && !start_hit && timeout_hit;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state       <= IDLE;
      grant       <= '0;
      owner_idx   <= '0;
      last_owner  <= IW'(MASTERS - 1);
      cnt         <= '0;
      ones        <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      timeout_err <= revoke;
      if (state == IDLE && sel_valid) begin
        grant     <= sel_onehot;
        owner_idx <= sel_idx;
      end else if (state_nxt == RELEASE || state_nxt == IDLE) begin
        grant <= '0;
      end
      if (state == GRANT) begin
        if (cnt != CW'(TIMEOUT)) cnt <= cnt + CW'(1);
        if (!control)                          ones <= '0;
        else if (ones != ONES_W'(START_LEN))   ones <= ones + ONES_W'(1);
      end else begin
        cnt  <= '0;
        ones <= '0;
      end
      if (state == RELEASE) last_owner <= owner_idx;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sel_valid) state_nxt = GRANT;
      GRANT: begin
        if (!owner_req)       state_nxt = RELEASE;
        else if (start_hit)   state_nxt = BUSY;
        else if (timeout_hit) state_nxt = RELEASE;
      end
      BUSY:    if (!owner_req) state_nxt = RELEASE;
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bus lines follow the registered one-hot grant; no owner means all zero.
  always_comb begin
    busy    = (state == GRANT) || (state == BUSY);
    control = |(grant & m_control);
    wD      = |(grant & m_wD);
    valid   = |(grant & m_valid);
    last    = |(grant & m_last);
    m_ready = grant & {MASTERS{ready}};
    m_rD    = grant & {MASTERS{rD}};
  end

endmodule

// File: tb/tb_serial_bus_arbiter.sv
// Self-checking bench for serial_bus_arbiter: directed scenarios followed by
// randomized traffic, all compared against a transaction-level model.
module tb_serial_bus_arbiter;

  localparam int M  = 2;
  localparam int TO = 16;

  logic         clk = 1'b0;
  logic         resetn;
  logic [M-1:0] req, grant, m_control, m_wD, m_valid, m_last, m_ready, m_rD;
  logic         control, wD, valid, last, ready, rD, busy, timeout_err;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: who owns the bus, how long, and how far along the start.
  int m_owner, m_last_owner, m_age, m_ones;
  bit m_gap, m_started, m_terr;

  serial_bus_arbiter #(.MASTERS(M), .TIMEOUT(TO)) dut (
    .clk(clk), .resetn(resetn), .req(req), .grant(grant),
    .m_control(m_control), .m_wD(m_wD), .m_valid(m_valid), .m_last(m_last),
    .control(control), .wD(wD), .valid(valid), .last(last),
    .ready(ready), .rD(rD), .m_ready(m_ready), .m_rD(m_rD),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_last_owner = M - 1; m_age = 0; m_ones = 0;
    m_gap = 0; m_started = 0; m_terr = 0;
  endtask

  task automatic model_release(input bit by_timeout);
    m_last_owner = m_owner;
    m_owner      = -1;
    m_gap        = 1;
    m_terr       = by_timeout;
  endtask

  task automatic model_step();
    m_terr = 0;
    if (m_gap) begin
      m_gap = 0;
    end else if (m_owner < 0) begin
      for (int i = 1; i <= M; i++) begin
        if (m_owner < 0 && req[(m_last_owner + i) % M]) begin
          m_owner = (m_last_owner + i) % M;
          m_age = 0; m_ones = 0; m_started = 0;
        end
      end
    end else if (!req[m_owner]) begin
      model_release(0);
    end else if (!m_started) begin
      m_age++;
      m_ones = m_control[m_owner] ? m_ones + 1 : 0;
      if (m_ones == 3)       m_started = 1;
      else if (m_age == TO)  model_release(1);
    end
  endtask

  task automatic check_outputs();
    logic [M-1:0] eg, emr, emd;
    logic ec, ew, ev, el;
    eg = '0; emr = '0; emd = '0; ec = 0; ew = 0; ev = 0; el = 0;
    if (m_owner >= 0) begin
      eg[m_owner]  = 1'b1;
      ec = m_control[m_owner]; ew = m_wD[m_owner];
      ev = m_valid[m_owner];   el = m_last[m_owner];
      emr[m_owner] = ready;    emd[m_owner] = rD;
    end
    check("grant", 32'(grant), 32'(eg));
    check("busy", 32'(busy), 32'(m_owner >= 0));
    check("timeout_err", 32'(timeout_err), 32'(m_terr));
    check("bus_lines", 32'({control, wD, valid, last}), 32'({ec, ew, ev, el}));
    check("m_ready", 32'(m_ready), 32'(emr));
    check("m_rD", 32'(m_rD), 32'(emd));
  endtask

  task automatic cycle();
    @(posedge clk);
    if (resetn) model_reset();
    else        model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset();
    resetn = 1'b1;
    model_reset();
    cycles(2);
    resetn = 1'b0;
  endtask

  int np;
  bit lazy [M];
  logic [5:0] pat;

  initial begin
    resetn = 1'b1; req = '0; m_control = '0; m_wD = '0; m_valid = '0; m_last = '0;
    ready = 1'b0; rD = 1'b0;
    model_reset();
    @(negedge clk);
    check_outputs();
    cycles(2);
    resetn = 1'b0;

    // Single request: grant one cycle after req, start, stream data, drop.
    req = 2'b01; m_control = 2'b01;
    cycle();
    check("single_grant", 32'(grant), 32'h1);
    cycles(3);
    for (int i = 0; i < 4; i++) begin
      m_wD = 2'($urandom); m_valid = 2'b11; m_last = 2'(i == 3);
      cycle();
    end
    req = 2'b00; m_valid = '0; m_last = '0;
    cycle();
    check("single_release", 32'(grant), 32'h0);
    cycles(2);

    // Contention after reset: master 0 first, then master 1 after one idle cycle.
    do_reset();
    req = 2'b11; m_control = 2'b11;
    cycles(8);
    req = 2'b10;
    cycles(3);
    check("contention_next", 32'(grant), 32'h2);
    cycles(3);
    req = 2'b00;
    cycles(3);

    // Timeout: no start from master 0, single error pulse, master 1 next.
    do_reset();
    req = 2'b11; m_control = 2'b00;
    cycle();
    np = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (timeout_err) np++;
    end
    check("timeout_pulses", 32'(np), 32'd1);
    check("timeout_next_owner", 32'(grant), 32'h2);

    // Response isolation while master 1 owns the bus.
    req = 2'b10; m_control = 2'b10; ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      rD = i[0];
      cycle();
      check("iso_m0", 32'({m_ready[0], m_rD[0]}), 32'h0);
      check("iso_m1_rD", 32'(m_rD[1]), 32'(rD));
    end
    req = 2'b00; ready = 1'b0; rD = 1'b0;
    cycles(3);

    // Broken start 1,1,0,1,1,1 finishing on GRANT cycle 15: must reach BUSY.
    do_reset();
    pat = 6'b111011;
    req = 2'b01; m_control = 2'b00;
    cycle();
    cycles(9);
    for (int i = 0; i < 6; i++) begin
      m_control[0] = pat[i];
      cycle();
    end
    m_control = 2'b00;
    cycles(6);
    check("broken_start_held", 32'(grant), 32'h1);
    req = 2'b00;
    cycles(3);

    // 1,1,0,1 then silence: partial run must not count, so it times out.
    req = 2'b01; m_control = 2'b01;
    cycle();
    pat = 6'b001011;
    for (int i = 0; i < 6; i++) begin
      m_control[0] = pat[i];
      cycle();
    end
    cycles(10);
    check("partial_start_timeout", 32'(grant), 32'h0);
    req = 2'b00;
    cycles(3);

    // Asynchronous reset while BUSY clears everything immediately.
    req = 2'b01; m_control = 2'b01; ready = 1'b1; rD = 1'b1; m_valid = 2'b11;
    cycles(6);
    #2 resetn = 1'b1;
    #1;
    model_reset();
    check("areset_grant", 32'(grant), 32'h0);
    check("areset_busy", 32'({busy, timeout_err}), 32'h0);
    check("areset_bus", 32'({control, wD, valid, last}), 32'h0);
    check("areset_resp", 32'({m_ready, m_rD}), 32'h0);
    @(negedge clk);
    resetn = 1'b0; req = 2'b11; ready = 1'b0; rD = 1'b0; m_valid = '0;
    cycle();
    check("areset_priority", 32'(grant), 32'h1);
    req = 2'b00;
    cycles(3);

    // Randomized traffic with occasional lazy masters to provoke timeouts.
    for (int c = 0; c < 600; c++) begin
      if (c % 50 == 0)
        for (int i = 0; i < M; i++) lazy[i] = ($urandom_range(3) == 0);
      for (int i = 0; i < M; i++) begin
        if ($urandom_range(7) == 0) req[i] = ~req[i];
        m_control[i] = lazy[i] ? ($urandom_range(3) == 0) : ($urandom_range(3) != 0);
      end
      m_wD = 2'($urandom); m_valid = 2'($urandom); m_last = 2'($urandom);
      ready = 1'($urandom); rD = 1'($urandom);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
